light_seq_monitor: RTL and testbench
====================================

Name: light_seq_monitor

Overview:
- Receiving-end checker for the 3-bit light-sequence generator output {A,B,C}.
- Samples the pattern each cycle and tracks legal progress through 000 -> 001 -> 011 -> 111 -> 000.
- Counts completed sequences and flags protocol violations (illegal codes, skipped or held steps).
- Sits beside the generator in the lab top level; its outputs drive LEDs and the debug counter.

Parameters:
CNT_W, 8, width of completed-sequence counter (saturating)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
a  in  1  observed light A (MSB of pattern)
b  in  1  observed light B
c  in  1  observed light C (LSB of pattern)
clr  in  1  synchronous clear of error flag, err_code and seq_count
phase  out  2  index of last accepted pattern: 0=000, 1=001, 2=011, 3=111
in_sync  out  1  monitor is locked to the sequence
seq_done  out  1  one-cycle pulse: a full 001->011->111->000 sequence completed
error  out  1  sticky violation flag
err_code  out  2  first-error cause: 00 none, 01 illegal code, 10 bad transition
seq_count  out  CNT_W  number of completed sequences, saturates at all-ones

Behaviour:
- One clock; reset is asynchronous and active-low. reset_n low forces the following immediately:
  - state=SYNC, phase=0, in_sync=0, seq_done=0, error=0, err_code=00, seq_count=0.
- All outputs are registered. A pattern present before rising edge k is reflected in outputs after edge k (latency 1).
- Pattern classify: 000, 001, 011 and 111 are legal, with index 0..3. 010, 100, 101 and 110 are illegal codes.
- States:
  - SYNC: not locked, no errors raised. Pattern 000 -> LOCKED with phase=0. Any other pattern stays in SYNC.
  - LOCKED: compares the sampled pattern against phase.
- Legal transitions from LOCKED:
  - phase 0: 000 stays at phase 0 (idle, unlimited). 001 -> phase 1.
  - phase 1 -> 011 (phase 2).
  - phase 2 -> 111 (phase 3).
  - phase 3 -> 000 (phase 0). Pulse seq_done and increment seq_count, saturating.
- Violations in LOCKED:
  - Illegal code: err_code candidate 01.
  - Legal code that is not the required successor (including holding 001/011/111 for 2+ cycles, or skipping a step): candidate 10.
  - On either violation: error<=1; err_code<=candidate only if error was 0 (first error kept); state->SYNC; phase<=0.
- in_sync = (state==LOCKED).
- clr:
  - Clears error, err_code and seq_count. Does not change state or phase.
  - A violation in the same cycle wins: error=1, err_code=new cause.
  - A completion in the same cycle: seq_done still pulses, seq_count=0.
- Saturation: at seq_count all-ones, further completions pulse seq_done but do not change the count.
- Reset mid-sequence on either side: after the generator resets to 000, the monitor (in SYNC or LOCKED phase 0) relocks without error.
  - A monitor reset during a non-000 pattern waits silently in SYNC.

Decomposition:
- Package light_seq_pkg holds:
  - pattern constants PAT_S0=3'b000, PAT_S1=3'b001, PAT_S2=3'b011, PAT_S3=3'b111;
  - err codes ERR_NONE, ERR_CODE, ERR_TRANS;
  - state encoding SYNC/LOCKED.
- One combinational sub-module, light_pat_decode: {a,b,c} -> legal (1), index (2). The top holds the FSM, error capture and counter.

Test Plan:
- Reset release with abc=000, then 001,011,111,000 on consecutive cycles -> in_sync=1 after first edge; seq_done pulses once after the 000 edge; seq_count=1; error=0.
- Reset release with abc=011 held 3 cycles, then 000 -> in_sync stays 0, no error, then in_sync=1.
- Locked at phase 1, drive 010 -> error=1, err_code=01, in_sync=0. Then 000 -> relock. A later hold of 011 for 2 cycles keeps err_code=01 (first error).
- Locked, drive 000 then 011 (skip) -> error=1, err_code=10. Assert clr one cycle -> error=0, err_code=00, seq_count=0.
- CNT_W=2, run 5 full sequences -> seq_count 1,2,3,3,3; seq_done pulses 5 times.
- clr asserted on the same edge as the 111->000 completion -> seq_done=1, seq_count=0. clr on the same edge as an illegal code -> error=1, err_code=01.

Source files
------------

// File: rtl/light_seq_pkg.sv
// rtl/light_seq_pkg.sv - shared constants and types for the light-sequence monitor
package light_seq_pkg;

  localparam logic [2:0] PAT_S0 = 3'b000;
  localparam logic [2:0] PAT_S1 = 3'b001;
  localparam logic [2:0] PAT_S2 = 3'b011;
  localparam logic [2:0] PAT_S3 = 3'b111;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_CODE  = 2'b01,
    ERR_TRANS = 2'b10
  } err_e;

  typedef enum logic {
    SYNC   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/light_seq_monitor_if.sv
// rtl/light_seq_monitor_if.sv - observed pattern, clear and status bundle of the monitor
interface light_seq_monitor_if #(parameter int CNT_W = 8);

  logic             a;
  logic             b;
  logic             c;
  logic             clr;
  logic [1:0]       phase;
  logic             in_sync;
  logic             seq_done;
  logic             error;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] seq_count;

  modport master (
    output a, b, c, clr,
    input  phase, in_sync, seq_done, error, err_code, seq_count
  );

  modport slave (
    input  a, b, c, clr,
    output phase, in_sync, seq_done, error, err_code, seq_count
  );

endinterface

// File: rtl/light_pat_decode.sv
// rtl/light_pat_decode.sv - classifies a 3-bit light pattern into legal flag and step index
module light_pat_decode
  import light_seq_pkg::*;
(
  input  logic [2:0] pat,
  output logic       legal,
  output logic [1:0] index
);

  always_comb begin
    legal = 1'b1;
    index = 2'd0;
    case (pat)
      PAT_S0:  index = 2'd0;
      PAT_S1:  index = 2'd1;
      PAT_S2:  index = 2'd2;
      PAT_S3:  index = 2'd3;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/light_seq_monitor.sv
// rtl/light_seq_monitor.sv - locks onto the 000/001/011/111 light cycle, counts completions, flags violations
module light_seq_monitor
  import light_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  light_seq_monitor_if.slave  mon
);

  logic [2:0]       pat;
  logic             pat_legal;
  logic [1:0]       pat_idx;
  logic [1:0]       succ;

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             seq_done_q, seq_done_d;
  logic             error_q, error_d;
  err_e             err_code_q, err_code_d;
  logic [CNT_W-1:0] seq_count_q, seq_count_d;

  logic             viol;
  err_e             cause;
  logic             complete;

  assign pat  = {mon.a, mon.b, mon.c};
  assign succ = phase_q + 2'd1;

  light_pat_decode u_decode (
    .pat   (pat),
    .legal (pat_legal),
    .index (pat_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SYNC;
      phase_q     <= 2'd0;
      seq_done_q  <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      seq_count_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      seq_done_q  <= seq_done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      seq_count_q <= seq_count_d;
    end
  end

  // Successor of phase 3 wraps to 0, so the 111->000 step needs no special case.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    viol     = 1'b0;
    cause    = ERR_NONE;
    complete = 1'b0;
    case (state_q)
      SYNC: begin
        if (pat_legal && pat_idx == 2'd0) begin
          state_d = LOCKED;
          phase_d = 2'd0;
        end
      end
      LOCKED: begin
        if (!pat_legal) begin
          viol  = 1'b1;
          cause = ERR_CODE;
        end else if (pat_idx == succ) begin
          phase_d  = pat_idx;
          complete = (phase_q == 2'd3);
        end else if (!(phase_q == 2'd0 && pat_idx == 2'd0)) begin
          viol  = 1'b1;
          cause = ERR_TRANS;
        end
        if (viol) begin
          state_d = SYNC;
          phase_d = 2'd0;
        end
      end
    endcase
  end

  // A violation overrides clr; without clr the first recorded cause is kept.
  always_comb begin
    seq_done_d  = complete;
    error_d     = error_q;
    err_code_d  = err_code_q;
    seq_count_d = seq_count_q;
    if (mon.clr) begin
      error_d     = 1'b0;
      err_code_d  = ERR_NONE;
      seq_count_d = '0;
    end else if (complete && seq_count_q != {CNT_W{1'b1}}) begin
      seq_count_d = seq_count_q + CNT_W'(1);
    end
    if (viol) begin
      error_d    = 1'b1;
      err_code_d = (error_q && !mon.clr) ? err_code_q : cause;
    end
  end

  assign mon.phase     = phase_q;
  assign mon.in_sync   = (state_q == LOCKED);
  assign mon.seq_done  = seq_done_q;
  assign mon.error     = error_q;
  assign mon.err_code  = err_code_q;
  assign mon.seq_count = seq_count_q;

endmodule

// File: tb/tb_light_seq_monitor.sv
// tb/tb_light_seq_monitor.sv - directed vector bench for light_seq_monitor
module tb_light_seq_monitor;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  light_seq_monitor_if #(.CNT_W(8)) if8 ();
  light_seq_monitor_if #(.CNT_W(2)) if2 ();

  light_seq_monitor #(.CNT_W(8)) dut8 (.clk(clk), .reset_n(reset_n), .mon(if8.slave));
  light_seq_monitor #(.CNT_W(2)) dut2 (.clk(clk), .reset_n(reset_n), .mon(if2.slave));

  typedef struct {
    logic [2:0] abc;
    logic       clr;
    logic [1:0] ph;
    logic       sync;
    logic       done;
    logic       err;
    logic [1:0] code;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] abc, logic clr, logic [1:0] ph, logic sync,
                              logic done, logic err, logic [1:0] code, logic [7:0] cnt);
    vec_t v;
    v.abc = abc; v.clr = clr; v.ph = ph; v.sync = sync;
    v.done = done; v.err = err; v.code = code; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [1:0] ph, input logic sync, input logic done,
                      input logic err, input logic [1:0] code, input logic [7:0] cnt);
    chk({tag, ".phase"},     32'(if8.phase),     32'(ph));
    chk({tag, ".in_sync"},   32'(if8.in_sync),   32'(sync));
    chk({tag, ".seq_done"},  32'(if8.seq_done),  32'(done));
    chk({tag, ".error"},     32'(if8.error),     32'(err));
    chk({tag, ".err_code"},  32'(if8.err_code),  32'(code));
    chk({tag, ".seq_count"}, 32'(if8.seq_count), 32'(cnt));
  endtask

  task automatic drive(input logic [2:0] abc, input logic clr);
    {if8.a, if8.b, if8.c} = abc;
    {if2.a, if2.b, if2.c} = abc;
    if8.clr = clr;
    if2.clr = clr;
  endtask

  task automatic step(input logic [2:0] abc, input logic clr);
    drive(abc, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] abc);
    drive(abc, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // abc, clr -> phase, in_sync, seq_done, error, err_code, seq_count
    vecs.push_back(mk(3'b000, 0, 0, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk(3'b001, 0, 1, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk(3'b011, 0, 2, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk(3'b111, 0, 3, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk(3'b000, 0, 0, 1, 1, 0, 2'b00, 1));
    vecs.push_back(mk(3'b000, 0, 0, 1, 0, 0, 2'b00, 1));
    vecs.push_back(mk(3'b001, 0, 1, 1, 0, 0, 2'b00, 1));
    vecs.push_back(mk(3'b010, 0, 0, 0, 0, 1, 2'b01, 1));
    vecs.push_back(mk(3'b011, 0, 0, 0, 0, 1, 2'b01, 1));
    vecs.push_back(mk(3'b000, 0, 0, 1, 0, 1, 2'b01, 1));
    vecs.push_back(mk(3'b001, 0, 1, 1, 0, 1, 2'b01, 1));
    vecs.push_back(mk(3'b011, 0, 2, 1, 0, 1, 2'b01, 1));
    vecs.push_back(mk(3'b011, 0, 0, 0, 0, 1, 2'b01, 1));
    vecs.push_back(mk(3'b000, 0, 0, 1, 0, 1, 2'b01, 1));
    vecs.push_back(mk(3'b000, 1, 0, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk(3'b011, 0, 0, 0, 0, 1, 2'b10, 0));
    vecs.push_back(mk(3'b000, 1, 0, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk(3'b001, 0, 1, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk(3'b011, 0, 2, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk(3'b111, 0, 3, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk(3'b000, 0, 0, 1, 1, 0, 2'b00, 1));
    vecs.push_back(mk(3'b001, 0, 1, 1, 0, 0, 2'b00, 1));
    vecs.push_back(mk(3'b011, 0, 2, 1, 0, 0, 2'b00, 1));
    vecs.push_back(mk(3'b111, 0, 3, 1, 0, 0, 2'b00, 1));
    vecs.push_back(mk(3'b000, 1, 0, 1, 1, 0, 2'b00, 0));
    vecs.push_back(mk(3'b001, 0, 1, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk(3'b101, 1, 0, 0, 0, 1, 2'b01, 0));
    vecs.push_back(mk(3'b000, 0, 0, 1, 0, 1, 2'b01, 0));
    vecs.push_back(mk(3'b001, 0, 1, 1, 0, 1, 2'b01, 0));
    vecs.push_back(mk(3'b111, 0, 0, 0, 0, 1, 2'b01, 0));
    vecs.push_back(mk(3'b100, 0, 0, 0, 0, 1, 2'b01, 0));
    vecs.push_back(mk(3'b000, 0, 0, 1, 0, 1, 2'b01, 0));
    vecs.push_back(mk(3'b000, 1, 0, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk(3'b001, 0, 1, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk(3'b001, 0, 0, 0, 0, 1, 2'b10, 0));

    drive(3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk8("reset", 0, 0, 0, 0, 2'b00, 0);
    chk("reset.seq_count2", 32'(if2.seq_count), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].abc, vecs[i].clr);
      chk8($sformatf("vec%0d", i), vecs[i].ph, vecs[i].sync, vecs[i].done,
           vecs[i].err, vecs[i].code, vecs[i].cnt);
    end

    // Monitor comes out of reset mid-sequence: waits silently until 000.
    do_reset(3'b011);
    for (int i = 0; i < 3; i++) begin
      step(3'b011, 1'b0);
      chk8($sformatf("sync_hold%0d", i), 0, 0, 0, 0, 2'b00, 0);
    end
    step(3'b000, 1'b0);
    chk8("sync_lock", 0, 1, 0, 0, 2'b00, 0);

    // Asynchronous reset between edges, then generator restarts from 011.
    step(3'b001, 1'b0);
    step(3'b011, 1'b0);
    chk8("pre_async", 2, 1, 0, 0, 2'b00, 0);
    reset_n = 1'b0;
    #1;
    chk8("async_reset", 0, 0, 0, 0, 2'b00, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(3'b011, 1'b0);
    step(3'b111, 1'b0);
    chk8("after_reset_wait", 0, 0, 0, 0, 2'b00, 0);
    step(3'b000, 1'b0);
    chk8("after_reset_lock", 0, 1, 0, 0, 2'b00, 0);

    // Saturation: 8-bit counter keeps counting, 2-bit counter sticks at 3.
    do_reset(3'b000);
    step(3'b000, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(3'b001, 1'b0);
      step(3'b011, 1'b0);
      step(3'b111, 1'b0);
      step(3'b000, 1'b0);
      chk($sformatf("sat%0d.done8", k), 32'(if8.seq_done), 32'd1);
      chk($sformatf("sat%0d.done2", k), 32'(if2.seq_done), 32'd1);
      chk($sformatf("sat%0d.cnt8", k), 32'(if8.seq_count), 32'(k));
      chk($sformatf("sat%0d.cnt2", k), 32'(if2.seq_count), 32'((k > 3) ? 3 : k));
    end
    step(3'b000, 1'b0);
    chk("sat_idle.done2", 32'(if2.seq_done), 32'd0);
    chk("sat_idle.cnt2", 32'(if2.seq_count), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
